// File: rtl/sfr_access_ctrl_pkg.sv
// Shared constants for the SFR access controller.
//  - SFR byte addresses of the core-side SFR blocks (B, ACC, PSW).
//  - FSM state encoding of the access sequencer (2-bit).
//  - sfr_byte_addr(): byte address of the SFR that holds a given bit address.
package sfr_access_ctrl_pkg;

  localparam logic [7:0] SFR_PSW = 8'hD0;
  localparam logic [7:0] SFR_ACC = 8'hE0;
  localparam logic [7:0] SFR_B   = 8'hF0;

  typedef enum logic [1:0] {
    SFRA_IDLE  = 2'd0,
    SFRA_READ  = 2'd1,
    SFRA_WRITE = 2'd2,
    SFRA_RESP  = 2'd3
  } sfra_state_e;

  function automatic logic [7:0] sfr_byte_addr(input logic [7:0] bit_addr);
    return {bit_addr[7:3], 3'b000};
  endfunction

endpackage

// File: rtl/sfr_access_ctrl_if.sv
// Request/response and SFR-bus signal bundle of the SFR access controller.
//  master : the controller (accepts req_*, returns rsp_*, drives sfr_* strobes,
//           receives sfr_data_in)
//  slave  : the surroundings (execute unit + SFR blocks), opposite directions
interface sfr_access_ctrl_if;

  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic       req_bit;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       req_wbit;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_rbit;
  logic [7:0] sfr_addr;
  logic [7:0] sfr_data_out;
  logic       sfr_write_en;
  logic       sfr_write_bit_en;
  logic       sfr_bit_out;
  logic [7:0] sfr_data_in;

  modport master (
    input  req_valid, req_write, req_bit, req_addr, req_wdata, req_wbit, sfr_data_in,
    output req_ready, rsp_valid, rsp_rdata, rsp_rbit,
           sfr_addr, sfr_data_out, sfr_write_en, sfr_write_bit_en, sfr_bit_out
  );

  modport slave (
    output req_valid, req_write, req_bit, req_addr, req_wdata, req_wbit, sfr_data_in,
    input  req_ready, rsp_valid, rsp_rdata, rsp_rbit,
           sfr_addr, sfr_data_out, sfr_write_en, sfr_write_bit_en, sfr_bit_out
  );

endinterface

// File: rtl/sfr_access_ctrl_bit_merge.sv
// sfr_bit_merge: combinational bit extract / bit insert on an SFR byte.
//  byte_in  in  8  byte read from the SFR bus
//  idx      in  3  bit index
//  bit_out  out 1  byte_in[idx]
// With SFR_BIT_RMW_EN defined the insert path is also built:
//  bit_in   in  1  replacement bit
//  byte_out out 8  byte_in with bit idx replaced by bit_in
module sfr_bit_merge (
`ifdef SFR_BIT_RMW_EN
  input  logic       bit_in,
  output logic [7:0] byte_out,
`endif
  input  logic [7:0] byte_in,
  input  logic [2:0] idx,
  output logic       bit_out
);

  assign bit_out = byte_in[idx];

`ifdef SFR_BIT_RMW_EN
  always_comb begin
    byte_out      = byte_in;
    byte_out[idx] = bit_in;
  end
`endif

endmodule

// File: rtl/sfr_access_ctrl.sv
// sfr_access_ctrl: core-side SFR bus initiator. Turns one CPU SFR request
// (byte/bit, read/write) into sequenced addr/data/write strobes and returns
// read data after READ_LATENCY cycles (legal 1..15).
//  clock  in  single clock, posedge
//  reset  in  asynchronous, active-low
//  bus    sfr_access_ctrl_if.master: req_* / rsp_* handshake and sfr_* bus
// Build option: SFR_BIT_RMW_EN -- bit writes run as read-modify-write with a
// byte write strobe; sfr_write_bit_en is tied low.
module sfr_access_ctrl
  import sfr_access_ctrl_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic               clock,
  input  logic               reset,
  sfr_access_ctrl_if.master  bus
);

  localparam logic [3:0] CNT_LOAD = 4'(READ_LATENCY - 1);

  sfra_state_e state, state_next;

  logic [3:0] cnt;
  logic [2:0] idx_q;
  logic       wbit_q;
  logic       ready_q;
  logic [7:0] addr_q;
  logic [7:0] data_q;
  logic       bit_out_q;
  logic [7:0] rdata_q;
  logic       rbit_q;
  logic       accept;
  logic       go_write;
  logic       sel_bit;
`ifdef SFR_BIT_RMW_EN
  logic       rmw_q;
  logic [7:0] merged;
`else
  logic       bit_q;
`endif

  sfr_bit_merge u_bit_merge (
`ifdef SFR_BIT_RMW_EN
    .bit_in   (wbit_q),
    .byte_out (merged),
`endif
    .byte_in  (bus.sfr_data_in),
    .idx      (idx_q),
    .bit_out  (sel_bit)
  );

  assign accept = (state == SFRA_IDLE) && bus.req_valid && ready_q;

  // Bit writes take the read path first when they are done as RMW.
`ifdef SFR_BIT_RMW_EN
  assign go_write = bus.req_write && !bus.req_bit;
`else
  assign go_write = bus.req_write;
`endif

  always_comb begin
    state_next = state;
    case (state)
      SFRA_IDLE:  if (accept) state_next = go_write ? SFRA_WRITE : SFRA_READ;
      SFRA_READ: begin
        if (cnt == '0) begin
`ifdef SFR_BIT_RMW_EN
          state_next = rmw_q ? SFRA_WRITE : SFRA_RESP;
`else
          state_next = SFRA_RESP;
`endif
        end
      end
      SFRA_WRITE: state_next = SFRA_RESP;
      SFRA_RESP:  state_next = SFRA_IDLE;
      default:    state_next = SFRA_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= SFRA_IDLE;
    else        state <= state_next;
  end

  // req_ready is registered so that it is low while reset is held and rises
  // on the first edge after release; otherwise it tracks state == IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ready_q   <= 1'b0;
      cnt       <= '0;
      idx_q     <= '0;
      wbit_q    <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      bit_out_q <= 1'b0;
      rdata_q   <= '0;
      rbit_q    <= 1'b0;
`ifdef SFR_BIT_RMW_EN
      rmw_q     <= 1'b0;
`else
      bit_q     <= 1'b0;
`endif
    end else begin
      ready_q <= (state_next == SFRA_IDLE);

      if (accept) begin
        idx_q  <= bus.req_addr[2:0];
        wbit_q <= bus.req_wbit;
        cnt    <= CNT_LOAD;
`ifdef SFR_BIT_RMW_EN
        rmw_q  <= bus.req_write && bus.req_bit;
`else
        bit_q  <= bus.req_bit;
`endif
        if (go_write) begin
          addr_q <= bus.req_addr;
          data_q <= bus.req_wdata;
          if (bus.req_bit) bit_out_q <= bus.req_wbit;
        end else begin
          addr_q <= bus.req_bit ? sfr_byte_addr(bus.req_addr) : bus.req_addr;
        end
      end

      if (state == SFRA_READ) begin
        if (cnt != '0) begin
          cnt <= cnt - 4'd1;
        end else begin
`ifdef SFR_BIT_RMW_EN
          if (rmw_q) begin
            data_q <= merged;
          end else begin
            rdata_q <= bus.sfr_data_in;
            rbit_q  <= sel_bit;
          end
`else
          rdata_q <= bus.sfr_data_in;
          rbit_q  <= sel_bit;
`endif
        end
      end

      if (state == SFRA_WRITE) begin
        rdata_q <= data_q;
        rbit_q  <= wbit_q;
      end
    end
  end

  assign bus.req_ready    = ready_q;
  assign bus.rsp_valid    = (state == SFRA_RESP);
  assign bus.rsp_rdata    = rdata_q;
  assign bus.rsp_rbit     = rbit_q;
  assign bus.sfr_addr     = addr_q;
  assign bus.sfr_data_out = data_q;
  assign bus.sfr_bit_out  = bit_out_q;
  assign bus.sfr_write_en = (state == SFRA_WRITE);
`ifdef SFR_BIT_RMW_EN
  assign bus.sfr_write_bit_en = 1'b0;
`else
  assign bus.sfr_write_bit_en = (state == SFRA_WRITE) && bit_q;
`endif

endmodule

// File: tb/tb_sfr_access_ctrl.sv
// Self-checking bench for sfr_access_ctrl (READ_LATENCY = 3). Honours the
// SFR_BIT_RMW_EN build option in its reference model.
module tb_sfr_access_ctrl;
  import sfr_access_ctrl_pkg::*;

  localparam int unsigned RL = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  last_rdata = '0;
  logic        last_rbit  = 1'b0;

  sfr_access_ctrl_if bus ();

  sfr_access_ctrl #(.READ_LATENCY(RL)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic scramble_req();
    bus.req_valid = 1'($urandom);
    bus.req_write = 1'($urandom);
    bus.req_bit   = 1'($urandom);
    bus.req_addr  = 8'($urandom);
    bus.req_wdata = 8'($urandom);
    bus.req_wbit  = 1'($urandom);
  endtask

  // Entered and left at a negedge where the DUT is idle.
  task automatic do_op(input logic wr, input logic bt, input logic [7:0] addr,
                       input logic [7:0] wdata, input logic wb, input logic [7:0] sfr_byte);
    logic        rmw;
    int unsigned idx;
    int          nr;
    logic [7:0]  mask, merged, rd_addr, wr_addr, exp_wdata, exp_rdata;
    logic        exp_rbit;
    rmw = 1'b0;
`ifdef SFR_BIT_RMW_EN
    rmw = wr & bt;
`endif
    idx       = int'(addr % 8);
    mask      = 8'(1 << idx);
    merged    = wb ? (sfr_byte | mask) : (sfr_byte & ~mask);
    rd_addr   = bt ? (addr - 8'(idx)) : addr;
    wr_addr   = rmw ? rd_addr : addr;
    nr        = (!wr || rmw) ? int'(RL) : 0;
    exp_wdata = rmw ? merged : wdata;
    exp_rdata = wr ? exp_wdata : sfr_byte;
    exp_rbit  = wr ? wb : 1'((sfr_byte >> idx) & 8'd1);

    bus.req_valid   = 1'b1;
    bus.req_write   = wr;
    bus.req_bit     = bt;
    bus.req_addr    = addr;
    bus.req_wdata   = wdata;
    bus.req_wbit    = wb;
    bus.sfr_data_in = sfr_byte ^ 8'($urandom_range(1, 255));

    for (int i = 0; i < nr; i++) begin
      @(negedge clock);
      check_eq("rd_addr", bus.sfr_addr, rd_addr);
      check_eq("rd_write_en", 8'(bus.sfr_write_en), 8'd0);
      check_eq("rd_write_bit_en", 8'(bus.sfr_write_bit_en), 8'd0);
      check_eq("rd_rsp_valid", 8'(bus.rsp_valid), 8'd0);
      check_eq("rd_ready", 8'(bus.req_ready), 8'd0);
      scramble_req();
      bus.sfr_data_in = (i == nr - 1) ? sfr_byte : sfr_byte ^ 8'($urandom_range(1, 255));
    end

    if (wr) begin
      @(negedge clock);
      check_eq("wr_write_en", 8'(bus.sfr_write_en), 8'd1);
      check_eq("wr_write_bit_en", 8'(bus.sfr_write_bit_en), 8'(bt && !rmw));
      check_eq("wr_addr", bus.sfr_addr, wr_addr);
      if (!bt || rmw) check_eq("wr_data", bus.sfr_data_out, exp_wdata);
      if (bt && !rmw) check_eq("wr_bit_out", 8'(bus.sfr_bit_out), 8'(wb));
      check_eq("wr_rsp_valid", 8'(bus.rsp_valid), 8'd0);
      check_eq("wr_ready", 8'(bus.req_ready), 8'd0);
      scramble_req();
      bus.sfr_data_in = 8'($urandom);
    end

    @(negedge clock);
    check_eq("rsp_valid", 8'(bus.rsp_valid), 8'd1);
    check_eq("rsp_rdata", bus.rsp_rdata, exp_rdata);
    if (bt) check_eq("rsp_rbit", 8'(bus.rsp_rbit), 8'(exp_rbit));
    check_eq("rsp_write_en", 8'(bus.sfr_write_en), 8'd0);
    check_eq("rsp_write_bit_en", 8'(bus.sfr_write_bit_en), 8'd0);
    check_eq("rsp_ready", 8'(bus.req_ready), 8'd0);
    bus.req_valid = 1'b0;
    last_rdata = exp_rdata;
    last_rbit  = exp_rbit;

    @(negedge clock);
    check_eq("idle_ready", 8'(bus.req_ready), 8'd1);
    check_eq("idle_rsp_valid", 8'(bus.rsp_valid), 8'd0);
    check_eq("idle_write_en", 8'(bus.sfr_write_en), 8'd0);
    check_eq("rdata_hold", bus.rsp_rdata, last_rdata);
    if (bt) check_eq("rbit_hold", 8'(bus.rsp_rbit), 8'(last_rbit));
  endtask

  task automatic wait_ready_after_reset();
    int unsigned k = 0;
    @(negedge clock);
    while (bus.req_ready !== 1'b1 && k < 3) begin
      @(negedge clock);
      k++;
    end
    check_eq("ready_after_reset", 8'(bus.req_ready), 8'd1);
    check_eq("post_reset_write_en", 8'(bus.sfr_write_en), 8'd0);
    check_eq("post_reset_rsp_valid", 8'(bus.rsp_valid), 8'd0);
    last_rdata = '0;
    last_rbit  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_sfr_addr"}, bus.sfr_addr, 8'd0);
    check_eq({tag, "_data_out"}, bus.sfr_data_out, 8'd0);
    check_eq({tag, "_write_en"}, 8'(bus.sfr_write_en), 8'd0);
    check_eq({tag, "_write_bit_en"}, 8'(bus.sfr_write_bit_en), 8'd0);
    check_eq({tag, "_bit_out"}, 8'(bus.sfr_bit_out), 8'd0);
    check_eq({tag, "_rsp_valid"}, 8'(bus.rsp_valid), 8'd0);
    check_eq({tag, "_rsp_rdata"}, bus.rsp_rdata, 8'd0);
    check_eq({tag, "_rsp_rbit"}, 8'(bus.rsp_rbit), 8'd0);
    check_eq({tag, "_ready"}, 8'(bus.req_ready), 8'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] base;
    bus.req_valid   = 1'b0;
    bus.req_write   = 1'b0;
    bus.req_bit     = 1'b0;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.req_wbit    = 1'b0;
    bus.sfr_data_in = '0;

    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b1;
    wait_ready_after_reset();

    // Directed cases on B (F0) and its bit 3 (F3).
    do_op(1'b1, 1'b0, SFR_B, 8'hA5, 1'b0, 8'h00);
    do_op(1'b0, 1'b0, SFR_B, 8'h00, 1'b0, 8'h3C);
    do_op(1'b0, 1'b1, SFR_B | 8'h03, 8'h00, 1'b0, 8'h08);
    do_op(1'b0, 1'b1, SFR_B | 8'h02, 8'h00, 1'b0, 8'h08);
    do_op(1'b1, 1'b1, SFR_B | 8'h03, 8'h5A, 1'b1, 8'h00);
    do_op(1'b1, 1'b1, SFR_ACC | 8'h07, 8'h00, 1'b0, 8'hFF);
    do_op(1'b0, 1'b1, SFR_PSW | 8'h07, 8'h00, 1'b0, 8'h80);

    // Async reset in the middle of a read: everything clears, nothing follows.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_bit   = 1'b0;
    bus.req_addr  = SFR_B;
    @(negedge clock);
    bus.req_valid = 1'b0;
    @(negedge clock);
    #2 reset = 1'b0;
    #1 check_all_zero("mid_reset");
    repeat (2) begin
      @(negedge clock);
      check_eq("in_reset_write_en", 8'(bus.sfr_write_en), 8'd0);
      check_eq("in_reset_rsp_valid", 8'(bus.rsp_valid), 8'd0);
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check_eq("released_write_en", 8'(bus.sfr_write_en), 8'd0);
      check_eq("released_rsp_valid", 8'(bus.rsp_valid), 8'd0);
    end
    wait_ready_after_reset();

    // req_valid held high: one accept every 3 cycles, mid-op input changes ignored.
    bus.req_write = 1'b1;
    bus.req_bit   = 1'b0;
    for (int c = 0; c <= 30; c++) begin
      if (c > 0) @(negedge clock);
      check_eq("hold_ready", 8'(bus.req_ready), 8'(c % 3 == 0));
      check_eq("hold_write_en", 8'(bus.sfr_write_en), 8'(c % 3 == 1));
      check_eq("hold_rsp_valid", 8'(bus.rsp_valid), 8'(c % 3 == 2));
      if (c % 3 == 1) begin
        check_eq("hold_data", bus.sfr_data_out, 8'(c - 1));
        check_eq("hold_addr", bus.sfr_addr, SFR_ACC + 8'(c - 1));
      end
      if (c % 3 == 2) check_eq("hold_rsp_rdata", bus.rsp_rdata, 8'(c - 2));
      if (c == 30) begin
        bus.req_valid = 1'b0;
      end else begin
        bus.req_valid = 1'b1;
        bus.req_wdata = 8'(c);
        bus.req_addr  = SFR_ACC + 8'(c);
      end
    end
    last_rdata = 8'd27;

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 3))
        0:       base = SFR_B;
        1:       base = SFR_ACC;
        2:       base = SFR_PSW;
        default: base = 8'($urandom) & 8'hF8;
      endcase
      do_op(1'($urandom), 1'($urandom), base | 8'($urandom_range(0, 7)),
            8'($urandom), 1'($urandom), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
